// File: rtl/arm_pkg.sv
// Shared encodings for the ARM pipeline: ALU commands, shift types and
// forward-select codes.
package arm_pkg;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/arm_alu.sv
// Combinational ARM ALU. upd = 0 marks an unsupported command whose flags
// must not be written back.
module arm_alu
  import arm_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [3:0]    exeCmd,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  input  logic          vin,
  output logic [DW-1:0] res,
  output logic [3:0]    nzcv,
  output logic          upd
);

  logic [DW:0] sum;
  logic        c, v;

  always_comb begin
    sum = '0;
    res = '0;
    c   = cin;
    v   = vin;
    upd = 1'b1;
    case (exeCmd)
      EXE_MOV: res = b;
      EXE_MVN: res = ~b;
      EXE_ADD, EXE_ADC: begin
        sum = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, (exeCmd == EXE_ADC) & cin};
        res = sum[DW-1:0];
        c   = sum[DW];
        v   = (a[DW-1] == b[DW-1]) && (res[DW-1] != a[DW-1]);
      end
      EXE_SUB, EXE_SBC: begin
        // a - b - borrow as a + ~b + carry; carry-out is NOT borrow
        sum = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, (exeCmd == EXE_SUB) | cin};
        res = sum[DW-1:0];
        c   = sum[DW];
        v   = (a[DW-1] != b[DW-1]) && (res[DW-1] != a[DW-1]);
      end
      EXE_AND: res = a & b;
      EXE_ORR: res = a | b;
      EXE_EOR: res = a ^ b;
      default: upd = 1'b0;
    endcase
  end

  assign nzcv = {res[DW-1], (res == '0), c, v};

endmodule

// File: rtl/stage_ex.sv
// ARM execute stage: Val2 generation, ALU, branch target, NZCV and the EX/MEM
// register. Define FORWARDING_EN to take operands through the forwarding muxes.
module stage_ex
  import arm_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          flush,
  input  logic          valid,
  input  logic          wbEnIn,
  input  logic          memREnIn,
  input  logic          memWEnIn,
  input  logic          sIn,
  input  logic          bIn,
  input  logic          immIn,
  input  logic [3:0]    exeCmd,
  input  logic [DW-1:0] pcIn,
  input  logic [DW-1:0] valRn,
  input  logic [DW-1:0] valRm,
  input  logic [11:0]   shiftOperand,
  input  logic [23:0]   imm24,
  input  logic [RW-1:0] destIn,
  input  logic [1:0]    selSrc1,
  input  logic [1:0]    selSrc2,
  input  logic [DW-1:0] fwdMem,
  input  logic [DW-1:0] fwdWb,
  output logic          wbEnOut,
  output logic          memREnOut,
  output logic          memWEnOut,
  output logic [DW-1:0] aluResOut,
  output logic [DW-1:0] valRmOut,
  output logic [RW-1:0] destOut,
  output logic [3:0]    status,
  output logic          branchTaken,
  output logic [DW-1:0] branchAddr
);

  function automatic logic [DW-1:0] rotr(input logic [DW-1:0] x, input logic [4:0] n);
    rotr = (x >> n) | (x << (DW - int'(n)));
  endfunction

  logic [DW-1:0] opRn, opRm;

`ifdef FORWARDING_EN
  always_comb begin
    case (selSrc1)
      FWD_MEM: opRn = fwdMem;
      FWD_WB:  opRn = fwdWb;
      default: opRn = valRn;
    endcase
    case (selSrc2)
      FWD_MEM: opRm = fwdMem;
      FWD_WB:  opRm = fwdWb;
      default: opRm = valRm;
    endcase
  end
  logic unusedBits;
  assign unusedBits = shiftOperand[4];
`else
  assign opRn = valRn;
  assign opRm = valRm;
  logic unusedBits;
  assign unusedBits = ^{selSrc1, selSrc2, fwdMem, fwdWb, shiftOperand[4]};
`endif

  // Val2: rotated immediate, memory offset, or shifted Rm
  logic [DW-1:0] val2;
  logic [4:0]    shAmt;
  assign shAmt = shiftOperand[11:7];

  always_comb begin
    val2 = opRm;
    if (immIn)
      val2 = rotr({{(DW-8){1'b0}}, shiftOperand[7:0]}, {shiftOperand[11:8], 1'b0});
    else if (memREnIn || memWEnIn)
      val2 = {{(DW-12){1'b0}}, shiftOperand};
    else begin
      case (shiftOperand[6:5])
        SH_LSL: val2 = opRm << shAmt;
        SH_LSR: val2 = opRm >> shAmt;
        SH_ASR: val2 = DW'($signed(opRm) >>> shAmt);
        default: val2 = rotr(opRm, shAmt);
      endcase
    end
  end

  logic [DW-1:0] aluRes;
  logic [3:0]    aluNzcv;
  logic          aluUpd;

  arm_alu #(.DW(DW)) uAlu (
    .exeCmd (exeCmd),
    .a      (opRn),
    .b      (val2),
    .cin    (status[1]),
    .vin    (status[0]),
    .res    (aluRes),
    .nzcv   (aluNzcv),
    .upd    (aluUpd)
  );

  assign branchTaken = valid & bIn;
  assign branchAddr  = pcIn + {{(DW-26){imm24[23]}}, imm24, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      status <= '0;
    else if (valid && sIn && !freeze && aluUpd)
      status <= aluNzcv;
  end

  // freeze beats flush; a bubble clears data fields as well as controls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbEnOut   <= 1'b0;
      memREnOut <= 1'b0;
      memWEnOut <= 1'b0;
      aluResOut <= '0;
      valRmOut  <= '0;
      destOut   <= '0;
    end else if (!freeze) begin
      if (flush || !valid) begin
        wbEnOut   <= 1'b0;
        memREnOut <= 1'b0;
        memWEnOut <= 1'b0;
        aluResOut <= '0;
        valRmOut  <= '0;
        destOut   <= '0;
      end else begin
        wbEnOut   <= wbEnIn;
        memREnOut <= memREnIn;
        memWEnOut <= memWEnIn;
        aluResOut <= aluRes;
        valRmOut  <= opRm;
        destOut   <= destIn;
      end
    end
  end

endmodule

// File: tb/tb_stage_ex.sv
// Directed, table-driven bench for stage_ex plus freeze/flush, branch and
// async-reset sequences.
module tb_stage_ex;
  import arm_pkg::*;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, valid;
  logic        wbEnIn, memREnIn, memWEnIn, sIn, bIn, immIn;
  logic [3:0]  exeCmd;
  logic [31:0] pcIn, valRn, valRm, fwdMem, fwdWb;
  logic [11:0] shiftOperand;
  logic [23:0] imm24;
  logic [3:0]  destIn;
  logic [1:0]  selSrc1, selSrc2;
  logic        wbEnOut, memREnOut, memWEnOut, branchTaken;
  logic [31:0] aluResOut, valRmOut, branchAddr;
  logic [3:0]  destOut, status;

  int passCnt = 0;
  int totalCnt = 0;

  stage_ex dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid(valid),
    .wbEnIn(wbEnIn), .memREnIn(memREnIn), .memWEnIn(memWEnIn), .sIn(sIn),
    .bIn(bIn), .immIn(immIn), .exeCmd(exeCmd), .pcIn(pcIn), .valRn(valRn),
    .valRm(valRm), .shiftOperand(shiftOperand), .imm24(imm24), .destIn(destIn),
    .selSrc1(selSrc1), .selSrc2(selSrc2), .fwdMem(fwdMem), .fwdWb(fwdWb),
    .wbEnOut(wbEnOut), .memREnOut(memREnOut), .memWEnOut(memWEnOut),
    .aluResOut(aluResOut), .valRmOut(valRmOut), .destOut(destOut),
    .status(status), .branchTaken(branchTaken), .branchAddr(branchAddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic        s, imm, wb, mr, mw, vld;
    logic [31:0] rn, rm;
    logic [11:0] sh;
    logic [3:0]  dest;
    logic [31:0] expRes;
    logic [3:0]  expSt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] cmd, input logic s, imm, wb, mr, mw, vld,
                              input logic [31:0] rn, rm, input logic [11:0] sh,
                              input logic [3:0] dest, input logic [31:0] expRes,
                              input logic [3:0] expSt);
    vec_t v;
    v.cmd = cmd; v.s = s; v.imm = imm; v.wb = wb; v.mr = mr; v.mw = mw; v.vld = vld;
    v.rn = rn; v.rm = rm; v.sh = sh; v.dest = dest; v.expRes = expRes; v.expSt = expSt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    exeCmd = v.cmd; sIn = v.s; immIn = v.imm; wbEnIn = v.wb; memREnIn = v.mr;
    memWEnIn = v.mw; valid = v.vld; valRn = v.rn; valRm = v.rm;
    shiftOperand = v.sh; destIn = v.dest;
  endtask

  task automatic clkChk; @(posedge clk); #1; endtask

  initial begin
    rst = 1'b0; freeze = 0; flush = 0; valid = 0; bIn = 0;
    wbEnIn = 0; memREnIn = 0; memWEnIn = 0; sIn = 0; immIn = 0;
    exeCmd = 0; pcIn = 0; valRn = 0; valRm = 0; shiftOperand = 0; imm24 = 0;
    destIn = 0; selSrc1 = FWD_REG; selSrc2 = FWD_REG; fwdMem = 0; fwdWb = 0;

    //      cmd     s imm wb mr mw vld  rn            rm            sh      dst  expRes        st
    vecs.push_back(mk(EXE_ADD, 1,1,1,0,0,1, 32'h7FFFFFFF, 32'h0,        12'h001, 4'd1, 32'h80000000, 4'b1001));
    vecs.push_back(mk(EXE_SUB, 1,1,1,0,0,1, 32'd5,        32'h0,        12'h005, 4'd2, 32'h0,        4'b0110));
    vecs.push_back(mk(EXE_MOV, 0,1,1,0,0,1, 32'h0,        32'h0,        12'h1FF, 4'd3, 32'hC000003F, 4'b0110));
    vecs.push_back(mk(EXE_MOV, 0,0,1,0,0,1, 32'h0,        32'h80000000, 12'h240, 4'd4, 32'hF8000000, 4'b0110));
    vecs.push_back(mk(EXE_ADD, 0,0,0,0,1,1, 32'h400,      32'hDEAD,     12'h00C, 4'd3, 32'h40C,      4'b0110));
    vecs.push_back(mk(EXE_ADC, 1,1,1,0,0,1, 32'd1,        32'h0,        12'h002, 4'd5, 32'd4,        4'b0000));
    vecs.push_back(mk(EXE_SBC, 1,1,1,0,0,1, 32'd10,       32'h0,        12'h003, 4'd6, 32'd6,        4'b0010));
    vecs.push_back(mk(EXE_AND, 1,0,1,0,0,1, 32'hF0F0F0F0, 32'hFF00FF00, 12'h000, 4'd7, 32'hF000F000, 4'b1010));
    vecs.push_back(mk(EXE_ORR, 0,0,1,0,0,1, 32'h0F,       32'hF0,       12'h220, 4'd8, 32'h0F,       4'b1010));
    vecs.push_back(mk(EXE_EOR, 1,0,1,0,0,1, 32'hFF,       32'h1,        12'h400, 4'd9, 32'h1FF,      4'b0010));
    vecs.push_back(mk(EXE_MVN, 1,1,1,0,0,1, 32'h0,        32'h0,        12'h000, 4'd10,32'hFFFFFFFF, 4'b1010));
    vecs.push_back(mk(EXE_MOV, 0,0,1,0,0,1, 32'h0,        32'h1,        12'h0E0, 4'd11,32'h80000000, 4'b1010));
    vecs.push_back(mk(4'b0000, 1,0,1,0,0,1, 32'h5,        32'h7,        12'h000, 4'd12,32'h0,        4'b1010));
    vecs.push_back(mk(EXE_ADD, 1,1,1,1,0,0, 32'h5,        32'h7,        12'h001, 4'd13,32'h0,        4'b1010));
    vecs.push_back(mk(EXE_SUB, 1,1,1,0,0,1, 32'h0,        32'h0,        12'h001, 4'd14,32'hFFFFFFFF, 4'b1000));
    vecs.push_back(mk(EXE_SUB, 1,1,1,0,0,1, 32'h80000000, 32'h0,        12'h001, 4'd15,32'h7FFFFFFF, 4'b0011));

    #2;
    chk("reset aluResOut", aluResOut, 32'h0);
    chk("reset ctrl", {29'h0, wbEnOut, memREnOut, memWEnOut}, 32'h0);
    chk("reset status", {28'h0, status}, 32'h0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk); drive(vecs[i]);
      clkChk();
      chk($sformatf("v%0d aluRes", i), aluResOut, vecs[i].expRes);
      chk($sformatf("v%0d status", i), {28'h0, status}, {28'h0, vecs[i].expSt});
      chk($sformatf("v%0d ctrl", i), {29'h0, wbEnOut, memREnOut, memWEnOut},
          vecs[i].vld ? {29'h0, vecs[i].wb, vecs[i].mr, vecs[i].mw} : 32'h0);
      chk($sformatf("v%0d dest/rm", i), {destOut, valRmOut[27:0]},
          vecs[i].vld ? {vecs[i].dest, vecs[i].rm[27:0]} : 32'h0);
    end

    // freeze for 3 cycles while new flag-setting ops arrive
    @(negedge clk);
    drive(mk(EXE_ADD, 1,1,0,1,0,1, 32'h1, 32'h55, 12'h001, 4'd9, 32'h0, 4'h0));
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      clkChk();
      chk($sformatf("freeze%0d aluRes", i), aluResOut, 32'h7FFFFFFF);
      chk($sformatf("freeze%0d status", i), {28'h0, status}, 32'h3);
      chk($sformatf("freeze%0d ctrl", i), {29'h0, wbEnOut, memREnOut, memWEnOut}, 32'h4);
      @(negedge clk); valRn = valRn + 32'h10;
    end
    flush = 1;
    clkChk();
    chk("freeze+flush aluRes", aluResOut, 32'h7FFFFFFF);
    chk("freeze+flush ctrl", {29'h0, wbEnOut, memREnOut, memWEnOut}, 32'h4);
    @(negedge clk); freeze = 0; sIn = 0;
    clkChk();
    chk("flush ctrl", {29'h0, wbEnOut, memREnOut, memWEnOut}, 32'h0);
    chk("flush status", {28'h0, status}, 32'h3);
    @(negedge clk); flush = 0;

    // forwarding muxes: only honoured when the feature is built in
    drive(mk(EXE_ADD, 0,1,1,0,0,1, 32'h1, 32'hCD, 12'h001, 4'd2, 32'h0, 4'h0));
    selSrc1 = FWD_MEM; fwdMem = 32'h100; selSrc2 = FWD_WB; fwdWb = 32'hAB;
    clkChk();
`ifdef FORWARDING_EN
    chk("fwd aluRes", aluResOut, 32'h101);
    chk("fwd valRm", valRmOut, 32'hAB);
`else
    chk("nofwd aluRes", aluResOut, 32'h2);
    chk("nofwd valRm", valRmOut, 32'hCD);
`endif
    @(negedge clk); selSrc1 = FWD_REG; selSrc2 = FWD_REG;

    // branch target, combinational
    bIn = 1; pcIn = 32'h100; imm24 = 24'hFFFFFE; valid = 1;
    #1;
    chk("branchAddr back", branchAddr, 32'hF8);
    chk("branchTaken", {31'h0, branchTaken}, 32'h1);
    valid = 0; imm24 = 24'h000010; pcIn = 32'hFFFFFFF0;
    #1;
    chk("branchTaken !valid", {31'h0, branchTaken}, 32'h0);
    chk("branchAddr wrap", branchAddr, 32'h30);
    bIn = 0;

    // async reset mid-cycle
    @(negedge clk);
    drive(mk(EXE_MVN, 1,1,1,1,0,1, 32'h0, 32'h77, 12'h000, 4'd5, 32'h0, 4'h0));
    clkChk();
    chk("pre-reset aluRes", aluResOut, 32'hFFFFFFFF);
    chk("pre-reset status", {28'h0, status}, 32'hB);
    #2; rst = 0; #1;
    chk("async reset aluRes", aluResOut, 32'h0);
    chk("async reset regs", {wbEnOut, memREnOut, memWEnOut, destOut, valRmOut[24:0]}, 32'h0);
    chk("async reset status", {28'h0, status}, 32'h0);
    @(negedge clk); rst = 1;

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/stage_ex.md
Name: stage_ex

Overview:
- ARM execute stage: generates Val2 (immediate rotate, register shift, or memory offset), runs the ALU, and computes the branch target.
- Holds the NZCV status register and the EX→MEM pipeline register.
- Sits between the ID/EX register and the memory stage. Its registered outputs drive the memory stage directly.

Parameters:
- DW, 32, datapath width.
- RW, 4, register-index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  hold EX/MEM register and status register.
- flush  in  1  load bubble into EX/MEM register.
- valid  in  1  instruction in EX is valid.
- wbEnIn, memREnIn, memWEnIn, sIn, bIn, immIn  in  1 each  control bits from ID.
- exeCmd  in  4  ALU command.
- pcIn  in  32  PC+4 of the instruction.
- valRn, valRm  in  32  register operands.
- shiftOperand  in  12  instruction bits [11:0].
- imm24  in  24  branch offset.
- destIn  in  4  destination register.
- selSrc1, selSrc2  in  2  forward selects (0 = reg, 1 = MEM, 2 = WB).
- fwdMem, fwdWb  in  32  forwarded values.
- wbEnOut, memREnOut, memWEnOut  out  1  registered controls.
- aluResOut  out  32  registered ALU result / memory address.
- valRmOut  out  32  registered store data.
- destOut  out  4  registered destination.
- status  out  4  NZCV, bits [3:0] = {N,Z,C,V}.
- branchTaken  out  1  combinational = valid & bIn.
- branchAddr  out  32  combinational.

Behaviour:
- Reset (rst = 0, async): all registered outputs 0 and status = 0. Combinational outputs follow their inputs.
- Latency: one cycle from inputs to registered outputs. Status updates on the same clock edge.
- Val2 selection:
  - immIn = 1: {24'b0, shiftOperand[7:0]} rotated right by 2 × shiftOperand[11:8].
  - Otherwise, memREnIn | memWEnIn: zero-extended shiftOperand[11:0].
  - Otherwise: Rm shifted by shiftOperand[11:7]. Shift type from [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Shift amount 0 means no shift for all types.
- ALU (exeCmd):
  - 0001 MOV: Val2.
  - 1001 MVN: ~Val2.
  - 0010 ADD: Rn + Val2.
  - 0011 ADC: Rn + Val2 + C.
  - 0100 SUB: Rn − Val2.
  - 0101 SBC: Rn − Val2 − !C.
  - 0110 AND.
  - 0111 ORR.
  - 1000 EOR.
  - Any other code: result 0, flags unchanged.
  - CMP and TST reuse SUB and AND with wbEn = 0.
- Flags:
  - N = res[31]; Z = (res == 0).
  - C = carry-out for ADD/ADC; C = NOT borrow for SUB/SBC.
  - V = signed overflow for arithmetic ops.
  - Logical and move ops leave C and V unchanged.
- Status register write: only when valid & sIn & !freeze. freeze dominates.
- Branch: branchAddr = pcIn + (sign-extended imm24 << 2), wrap-around modulo 2^32.
- EX/MEM register priority:
  - freeze: hold all values.
  - else flush, or !valid: control bits 0; data fields don't-care, driven to 0.
  - else: capture new values.
- Simultaneous freeze and flush: freeze wins. The flush is lost, and the hazard unit must re-assert it.
- Memory address = Rn + Val2, via ADD, 32-bit truncation.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined:
  - Rn operand = mux(selSrc1: valRn / fwdMem / fwdWb).
  - Rm operand = mux(selSrc2: valRm / fwdMem / fwdWb).
  - Forwarded Rm also feeds valRmOut.
  - Select value 3 behaves as 0.
- Undefined:
  - selSrc1, selSrc2, fwdMem, fwdWb remain as ports but are ignored.
  - Operands come straight from valRn and valRm.

Decomposition:
- Shared package arm_pkg holds:
  - EXE_MOV, EXE_MVN, EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC, EXE_AND, EXE_ORR, EXE_EOR.
  - Shift types SH_LSL, SH_LSR, SH_ASR, SH_ROR.
  - Forward-select codes FWD_REG, FWD_MEM, FWD_WB.
- One natural sub-module: arm_alu, combinational (exeCmd, a, b, cin → res, nzcv).
- Val2 generator, operand muxes and registers stay in stage_ex.

Test Plan:
- ADD, sIn = 1, Rn = 0x7FFFFFFF, Val2 = 1 → next cycle aluResOut = 0x80000000, status = 1001 (N, V).
- SUB, Rn = 5, immIn = 1, shiftOperand = 0x005 → aluResOut = 0, status Z = 1, C = 1.
- immIn = 1, shiftOperand = 0x1FF (rotate 2 → ROR 2) → Val2 = 0xC000003F via MOV. Separately: Rm = 0x80000000 with ASR 4 → 0xF8000000.
- STR: memWEnIn = 1, Rn = 0x400, offset 0x00C, Rm = 0xDEAD → aluResOut = 0x40C, valRmOut = 0xDEAD, memWEnOut = 1.
- freeze held 3 cycles with new inputs applied → outputs and status unchanged. Next cycle with freeze = 1 and flush = 1 → still held. With flush alone → control outputs 0.
- bIn = 1, pcIn = 0x100, imm24 = 0xFFFFFE → branchAddr = 0xF8, branchTaken = 1. Assert rst = 0 mid-stream → all registered outputs 0 immediately, without waiting for a clock edge.
